system_top_mul_arbiter: RTL and testbench

Shares one 32-bit-signed × 28-bit-unsigned multiplier (48-bit result) among `N_REQ` requesters in the synchronization datapath. Each requester may issue at most one multiply per cycle. The arbiter grants one requester per cycle in round-robin order and pushes the operands through a `MUL_STAGES`-deep register pipeline around the combinational multiplier. Results return on a single tagged response bus that honours backpressure.

---
 rtl/system_top_mul_arb_pkg.sv | 36 +++
 rtl/system_top_mul_32s_28ns_48_1_1.sv | 25 ++
 rtl/system_top_mul_rr_arbiter.sv | 47 ++++
 rtl/system_top_mul_arbiter.sv | 112 +++++++++++
 tb/tb_system_top_mul_arbiter.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/system_top_mul_arb_pkg.sv
// Shared types and helpers for the shared-multiplier arbiter.
// Holds the operand/product widths, the pipeline-stage record and the
// rotate-priority search used by the round-robin arbiter.
package system_top_mul_arb_pkg;

  localparam int A_W      = 32;
  localparam int B_W      = 28;
  localparam int P_W      = 48;
  localparam int N_MAX    = 8;   // largest supported requester count
  localparam int ID_MAX_W = 3;   // tag width able to hold any index below N_MAX

  typedef struct packed {
    logic                valid;
    logic [ID_MAX_W-1:0] id;
    logic [P_W-1:0]      product;
  } mul_stage_t;

  // First set bit of valid in the order last+1, last+2, ... modulo n.
  // Returns -1 when nothing is valid. Scanning from the farthest offset
  // down lets the nearest hit overwrite the others without an early exit.
  function automatic int rr_next(input logic [N_MAX-1:0] valid,
                                 input int last,
                                 input int n);
    int sel;
    int idx;
    sel = -1;
    for (int k = N_MAX; k >= 1; k--) begin
      if (k <= n) begin
        idx = (last + k) % n;
        if (valid[idx[ID_MAX_W-1:0]]) sel = idx;
      end
    end
    return sel;
  endfunction

endpackage

// File: rtl/system_top_mul_32s_28ns_48_1_1.sv
// Combinational signed x unsigned multiplier, truncated to dout_WIDTH bits.
// Ports:
//   din0 - signed operand
//   din1 - unsigned operand (zero-extended before the signed multiply)
//   dout - low dout_WIDTH bits of the product
module system_top_mul_32s_28ns_48_1_1 #(
  parameter int din0_WIDTH = 32,
  parameter int din1_WIDTH = 28,
  parameter int dout_WIDTH = 48
) (
  input  logic [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0] din1,
  output logic [dout_WIDTH-1:0] dout
);

  // Extending both operands to the result width first keeps the low
  // dout_WIDTH bits of the product exact.
  logic signed [dout_WIDTH-1:0] a_ext;
  logic signed [dout_WIDTH-1:0] b_ext;

  assign a_ext = {{(dout_WIDTH-din0_WIDTH){din0[din0_WIDTH-1]}}, din0};
  assign b_ext = {{(dout_WIDTH-din1_WIDTH){1'b0}}, din1};
  assign dout  = a_ext * b_ext;

endmodule

// File: rtl/system_top_mul_rr_arbiter.sv
// Round-robin arbiter over N_REQ requesters; owns the last-granted pointer.
// Ports:
//   clk, rst    - clock, synchronous active-high reset
//   req_valid   - per-requester request
//   issue_en    - an issue may happen this cycle (no stall, not in reset)
//   grant       - one-hot grant, zero when nobody requests
//   grant_id    - encoded index of the granted requester
//   grant_valid - some requester is granted
module system_top_mul_rr_arbiter
  import system_top_mul_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req_valid,
  input  logic             issue_en,
  output logic [N_REQ-1:0] grant,
  output logic [ID_W-1:0]  grant_id,
  output logic             grant_valid
);

  logic [ID_W-1:0]  last_q;
  logic [N_MAX-1:0] valid_ext;
  int               sel;

  always_comb begin
    valid_ext = '0;
    valid_ext[N_REQ-1:0] = req_valid;
    sel         = rr_next(valid_ext, int'(last_q), N_REQ);
    grant_valid = (sel >= 0);
    grant_id    = grant_valid ? ID_W'(sel) : '0;
    grant       = grant_valid ? (N_REQ'(1) << grant_id) : '0;
  end

  // The pointer only moves on an accepted issue, so a stalled or empty
  // cycle leaves priority untouched.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= ID_W'(N_REQ - 1);
    end else if (issue_en && grant_valid) begin
      last_q <= grant_id;
    end
  end

endmodule

// File: rtl/system_top_mul_arbiter.sv
// Shares one 32s x 28u multiplier among N_REQ requesters. A round-robin
// grant selects the operands, the product enters a MUL_STAGES-deep
// pipeline, and the last stage drives a tagged response bus with
// backpressure (the whole pipeline freezes while the response is held).
// Ports:
//   ap_clk, ap_rst       - clock, synchronous active-high reset
//   req_valid/req_ready  - per-requester handshake (req_ready one-hot or 0)
//   req_a, req_b         - flattened operands, requester i at slice i
//   rsp_valid/rsp_ready  - response handshake
//   rsp_id, rsp_data     - requester tag and 48-bit product
//   busy                 - any pipeline stage holds a valid entry
module system_top_mul_arbiter
  import system_top_mul_arb_pkg::*;
#(
  parameter  int N_REQ      = 4,
  parameter  int MUL_STAGES = 2,
  localparam int ID_W       = $clog2(N_REQ)
) (
  input  logic               ap_clk,
  input  logic               ap_rst,
  input  logic [N_REQ-1:0]   req_valid,
  output logic [N_REQ-1:0]   req_ready,
  input  logic [N_REQ*A_W-1:0] req_a,
  input  logic [N_REQ*B_W-1:0] req_b,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [ID_W-1:0]    rsp_id,
  output logic [P_W-1:0]     rsp_data,
  output logic               busy
);

  logic             stall;
  logic             issue_en;
  logic [N_REQ-1:0] grant;
  logic [ID_W-1:0]  grant_id;
  logic             grant_valid;
  logic [A_W-1:0]   a_sel;
  logic [B_W-1:0]   b_sel;
  logic [P_W-1:0]   product;
  mul_stage_t       stage_in;
  mul_stage_t       stage_q [MUL_STAGES];
  mul_stage_t       head;
  logic             unused_id_hi;

  assign head     = stage_q[MUL_STAGES-1];
  assign stall    = head.valid & ~rsp_ready;
  assign issue_en = ~stall & ~ap_rst;
  assign req_ready = issue_en ? grant : '0;

  system_top_mul_rr_arbiter #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_arb (
    .clk         (ap_clk),
    .rst         (ap_rst),
    .req_valid   (req_valid),
    .issue_en    (issue_en),
    .grant       (grant),
    .grant_id    (grant_id),
    .grant_valid (grant_valid)
  );

  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i]) begin
        a_sel = req_a[i*A_W +: A_W];
        b_sel = req_b[i*B_W +: B_W];
      end
    end
  end

  system_top_mul_32s_28ns_48_1_1 #(
    .din0_WIDTH (A_W),
    .din1_WIDTH (B_W),
    .dout_WIDTH (P_W)
  ) u_mul (
    .din0 (a_sel),
    .din1 (b_sel),
    .dout (product)
  );

  // Bubbles carry a zero product so the response bus stays quiet.
  always_comb begin
    stage_in.valid   = grant_valid;
    stage_in.id      = ID_MAX_W'(grant_id);
    stage_in.product = grant_valid ? product : '0;
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      for (int i = 0; i < MUL_STAGES; i++) stage_q[i] <= '0;
    end else if (!stall) begin
      stage_q[0] <= stage_in;
      for (int i = 1; i < MUL_STAGES; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign rsp_valid = head.valid;
  assign rsp_id    = head.id[ID_W-1:0];
  assign rsp_data  = head.product;

  // Tag bits above ID_W are always zero for smaller N_REQ.
  assign unused_id_hi = ^head.id;

  always_comb begin
    busy = 1'b0;
    for (int i = 0; i < MUL_STAGES; i++) busy = busy | stage_q[i].valid;
  end

endmodule

// File: tb/tb_system_top_mul_arbiter.sv
module tb_system_top_mul_arbiter;
  localparam int N   = 4;
  localparam int S   = 2;
  localparam int IDW = 2;

  logic            ap_clk = 1'b0;
  logic            ap_rst;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*32-1:0] req_a;
  logic [N*28-1:0] req_b;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [IDW-1:0]  rsp_id;
  logic [47:0]     rsp_data;
  logic            busy;

  always #5 ap_clk = ~ap_clk;

  system_top_mul_arbiter #(.N_REQ(N), .MUL_STAGES(S)) dut (
    .ap_clk    (ap_clk),
    .ap_rst    (ap_rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .busy      (busy)
  );

  typedef struct {
    bit          v;
    int          id;
    logic [47:0] d;
  } ent_t;

  ent_t        line [S];   // model of what is in flight, index S-1 is the output
  ent_t        sb_q [$];   // expected responses in order
  int          m_last;
  int          checks = 0;
  int          errors = 0;
  bit          saw_rsp;
  logic [N-1:0] last_rdy;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [47:0] ref_mul(input logic [31:0] a, input logic [27:0] b);
    longint p;
    p = longint'($signed(a)) * longint'({36'd0, b});
    return p[47:0];
  endfunction

  function automatic int ref_grant(input logic [N-1:0] v, input int last);
    int sel;
    sel = -1;
    for (int k = 1; k <= N; k++) begin
      if (sel < 0 && v[(last + k) % N]) sel = (last + k) % N;
    end
    return sel;
  endfunction

  task automatic set_req(input int i, input logic [31:0] a, input logic [27:0] b);
    req_a[i*32 +: 32] = a;
    req_b[i*28 +: 28] = b;
  endtask

  task automatic rand_ops();
    for (int i = 0; i < N; i++) set_req(i, $urandom, 28'($urandom));
  endtask

  // One clock: compare DUT against the model at the falling edge, advance
  // the model for the coming rising edge, return 1 time unit after it.
  task automatic step();
    bit           m_out;
    bit           m_stall;
    bit           m_busy;
    int           g;
    logic [N-1:0] exp_rdy;
    @(negedge ap_clk);
    saw_rsp  = rsp_valid;
    last_rdy = req_ready;
    if (ap_rst) begin
      chk("ready_in_reset", 64'(req_ready), 64'd0);
      for (int i = 0; i < S; i++) line[i] = '{v: 0, id: 0, d: '0};
      sb_q.delete();
      m_last = N - 1;
    end else begin
      m_out   = line[S-1].v;
      m_stall = m_out & ~rsp_ready;
      m_busy  = 0;
      for (int i = 0; i < S; i++) m_busy |= line[i].v;
      g       = ref_grant(req_valid, m_last);
      exp_rdy = (g >= 0 && !m_stall) ? N'(1) << g : '0;
      chk("rsp_valid", 64'(rsp_valid), 64'(m_out));
      chk("busy", 64'(busy), 64'(m_busy));
      chk("req_ready", 64'(req_ready), 64'(exp_rdy));
      if (!m_stall) begin
        for (int i = S - 1; i > 0; i--) line[i] = line[i-1];
        if (g >= 0) begin
          line[0] = '{v: 1, id: g, d: ref_mul(req_a[g*32 +: 32], req_b[g*28 +: 28])};
          sb_q.push_back(line[0]);
          m_last = g;
        end else begin
          line[0] = '{v: 0, id: 0, d: '0};
        end
      end
    end
    @(posedge ap_clk);
    #1;
  endtask

  // Response monitor: pops the scoreboard on every handshake and checks
  // that a held response does not change.
  logic           hold_v = 1'b0;
  logic [IDW-1:0] hold_id;
  logic [47:0]    hold_d;
  ent_t           mon_e;

  always @(negedge ap_clk) begin
    if (ap_rst) begin
      hold_v = 1'b0;
    end else begin
      if (hold_v) begin
        chk("hold_id", 64'(rsp_id), 64'(hold_id));
        chk("hold_data", 64'(rsp_data), 64'(hold_d));
      end
      if (rsp_valid && rsp_ready) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_rsp", 64'd1, 64'd0);
        end else begin
          mon_e = sb_q.pop_front();
          chk("rsp_id", 64'(rsp_id), 64'(mon_e.id));
          chk("rsp_data", 64'(rsp_data), 64'(mon_e.d));
        end
      end
      hold_v  = rsp_valid & ~rsp_ready;
      hold_id = rsp_id;
      hold_d  = rsp_data;
    end
  end

  initial begin
    int lat;
    ap_rst    = 1'b1;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b1;
    m_last    = N - 1;
    for (int i = 0; i < S; i++) line[i] = '{v: 0, id: 0, d: '0};
    @(posedge ap_clk);
    #1;
    step();
    step();
    ap_rst = 1'b0;
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_rsp_id", 64'(rsp_id), 64'd0);
    chk("rst_rsp_data", 64'(rsp_data), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);

    // single issue and latency
    set_req(0, 32'hFFFF_FFFD, 28'd5);
    req_valid = 4'b0001;
    step();
    chk("single_grant", 64'(last_rdy), 64'd1);
    req_valid = '0;
    lat = -1;
    for (int k = 1; k <= 10; k++) begin
      step();
      if (saw_rsp) begin
        lat = k;
        break;
      end
    end
    chk("latency", 64'(lat), 64'(S));

    // width extremes
    req_valid = 4'b0001;
    set_req(0, 32'hFFFF_FFFF, 28'hFFF_FFFF); step();
    set_req(0, 32'h7FFF_FFFF, 28'hFFF_FFFF); step();
    set_req(0, 32'h8000_0000, 28'h0);        step();
    req_valid = '0;
    for (int k = 0; k < S + 2; k++) step();

    // round-robin fairness right after a reset
    ap_rst = 1'b1;
    step();
    ap_rst = 1'b0;
    req_valid = '1;
    for (int k = 0; k < 8; k++) begin
      rand_ops();
      step();
      chk("rr_grant", 64'(last_rdy), 64'(N'(1) << (k % N)));
    end

    // backpressure with requests pending
    rsp_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      rand_ops();
      step();
      chk("stall_ready", 64'(last_rdy), 64'd0);
    end
    rsp_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      rand_ops();
      step();
    end
    req_valid = '0;
    for (int k = 0; k < S + 2; k++) step();

    // sparse requests, then a 1-and-3 tie after last settles on 2
    for (int k = 0; k < 8; k++) begin
      rand_ops();
      req_valid = (k % 2 == 0) ? 4'b0100 : 4'b0000;
      step();
      if (k % 2 == 0) chk("sparse_grant", 64'(last_rdy), 64'h4);
    end
    req_valid = 4'b1010;
    step();
    chk("tie_first", 64'(last_rdy), 64'h8);
    step();
    chk("tie_second", 64'(last_rdy), 64'h2);
    req_valid = '0;
    for (int k = 0; k < S + 2; k++) step();

    // reset with the pipeline full
    req_valid = '1;
    for (int k = 0; k < S; k++) begin
      rand_ops();
      step();
    end
    ap_rst = 1'b1;
    step();
    ap_rst = 1'b0;
    chk("midrst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    rand_ops();
    step();
    chk("post_reset_grant", 64'(last_rdy), 64'd1);
    req_valid = '0;
    for (int k = 0; k < S + 2; k++) step();

    // randomized traffic with random backpressure and rare resets
    for (int k = 0; k < 400; k++) begin
      rand_ops();
      req_valid = N'($urandom);
      rsp_ready = ($urandom_range(0, 3) != 0);
      ap_rst    = ($urandom_range(0, 99) == 0);
      step();
    end
    ap_rst    = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b1;
    for (int k = 0; k < S + 4; k++) step();
    chk("drain_empty", 64'(sb_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
